// File: rtl/twos_complement_accumulator.sv
// Frame accumulator for signed two's-complement samples with a valid/ready result port.
// Define TCACC_SAT_EN to saturate on overflow; the default build wraps modulo 2^ACC_W.
module twos_complement_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  // Handshake: a sample moves on an edge with in_valid && in_ready; a frame
  // result moves on an edge with out_valid && out_ready. Both ready/valid
  // outputs are registered and only ever depend on the current state.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              ready_d, valid_d;

  logic signed [DATA_W-1:0] in_s;
  logic signed [ACC_W-1:0]  in_ext;
  logic [ACC_W-1:0]         sum_raw;
  logic [ACC_W-1:0]         add_res;
  logic                     add_ovf;

  assign in_s    = in_data;
  assign in_ext  = ACC_W'(in_s);
  assign sum_raw = acc_q + in_ext;
  assign add_ovf = (acc_q[ACC_W-1] == in_ext[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef TCACC_SAT_EN
  // Overflow direction follows the common sign of the two addends.
  always_comb begin
    add_res = sum_raw;
    if (add_ovf) begin
      add_res = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign add_res = sum_raw;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc_d = add_res;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
            if (cnt_q == LAST_CNT) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
    ready_d = (state_d == ACCUM);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      in_ready  <= ready_d;
      out_valid <= valid_d;
    end
  end

  assign out_sum = acc_q;
  assign out_ovf = ovf_q;

endmodule

// File: doc/twos_complement_accumulator.md
# twos_complement_accumulator

- Consumes the stream of signed two's-complement words produced by the 2's-complement generator stage and sums fixed-length frames of them.
- Inputs are sign-extended to `ACC_W` and added into a signed accumulator.
- After `FRAME_LEN` accepted samples, the frame total is presented on a valid/ready output port with a sticky overflow flag.
- Sits directly downstream of the generator and feeds the result-reporting logic.

## Interface
- `DATA_W`, 8 — input sample width, signed two's complement.
- `ACC_W`, 16 — accumulator and output width; must be ≥ `DATA_W`.
- `FRAME_LEN`, 4 — samples per frame; must be ≥ 1.

- `clk` input 1 — single clock, all logic on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `clear` input 1 — synchronous frame abort; highest priority after reset.
- `in_data` input `DATA_W` — signed sample.
- `in_valid` input 1 — `in_data` is valid.
- `in_ready` output 1 — block accepts a sample this cycle.
- `out_sum` output `ACC_W` — signed frame total.
- `out_ovf` output 1 — at least one add in this frame overflowed `ACC_W`.
- `out_valid` output 1 — `out_sum`/`out_ovf` hold a completed frame.
- `out_ready` input 1 — downstream consumes the frame.

## Operation
- Two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- ACCUM behaviour:
  - A sample is accepted on an edge where `in_valid && in_ready`.
  - On acceptance: acc ← acc + sext(`in_data`); count ← count+1; ovf ← ovf | add_ovf.
  - Accepting sample number `FRAME_LEN` moves the block to HOLD. `out_sum` and `out_ovf` then include that final sample.
- HOLD behaviour:
  - `out_sum` and `out_ovf` stay stable; `in_data` is ignored.
  - On an edge with `out_ready`=1: acc, count and ovf clear to 0, and the state returns to ACCUM.
- add_ovf is true when both addends have the same sign and the result's sign differs; width is `ACC_W`.
  - If `ACC_W` ≥ `DATA_W` + clog2(`FRAME_LEN`), overflow cannot occur.
- The counter width is clog2(`FRAME_LEN`+1). The counter never exceeds `FRAME_LEN`.
- `clear` forces the same state as reset, in any state and on the next edge:
  - acc, count and ovf go to 0; the state goes to ACCUM.
  - A pending frame is discarded, even if `out_ready` is high in the same cycle.
  - A sample presented in the same cycle is not accepted.

## Timing
- Reset values: `out_sum`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=0, state=ACCUM, count=0.
  - `in_ready` is registered. It rises on the first rising edge after `rst_n` deasserts.
- `rst_n` asserted mid-frame clears everything immediately, asynchronously. No partial frame is ever output.
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: `out_valid` rises on the edge that accepts the last sample, i.e. it is visible in the following cycle.
- HOLD→ACCUM costs the handshake edge only:
  - `in_ready` is 1 in the cycle after `out_valid && out_ready`.
  - Minimum frame period is `FRAME_LEN`+1 cycles.
- `in_valid` low in ACCUM: the state is unchanged. Gaps inside a frame are allowed.
- `out_ready` low in HOLD: the output is held indefinitely and no samples are accepted (backpressure).
- Asserting `out_ready` outside HOLD has no effect.

## Configuration
- `TCACC_SAT_EN` defined:
  - An overflowing add clamps acc to 2^(`ACC_W`-1)-1 on positive overflow, or -2^(`ACC_W`-1) on negative overflow.
  - Later adds start from the clamped value.
  - `out_ovf` is still set.
- `TCACC_SAT_EN` undefined: acc wraps modulo 2^`ACC_W`; `out_ovf` is set.
- With no overflow, behaviour is identical either way.

## Test plan
- Basic frame (defaults): feed 0x00, 0x0B, 0xFF, 0xD5 back-to-back with `out_ready`=1 → `out_valid` for 1 cycle, `out_sum`=0xFFDF (-33), `out_ovf`=0.
- Reset values and gaps: check every output value during and after reset. Then send the basic frame with `in_valid` low 2 cycles between samples → same result, and `in_ready`=1 throughout the gaps.
- Backpressure: hold `out_ready`=0 for 5 cycles after a frame of 0x01×4 → `out_sum`=0x0004 stable, `in_ready`=0. Release → next frame of 0x02×4 yields 0x0008.
- Overflow (`ACC_W`=8): feed 0x7F, 0x7F, 0x00, 0x00 → wrap build: 0xFE, `out_ovf`=1; `TCACC_SAT_EN` build: 0x7F, `out_ovf`=1. Feed 0x80, 0x80, 0, 0 → wrap: 0x00; sat: 0x80; `out_ovf`=1 in both.
- Clear/reset mid-operation:
  - After 2 samples, pulse `clear` → the next 4 samples 0x03 give 0x000C.
  - Assert `clear` together with `out_ready` in HOLD → frame dropped, `out_valid`=0 next cycle.
  - Drop `rst_n` mid-frame → outputs go to 0 immediately.
